dsm_upconv_param: RTL and testbench

//  Parametrised digital up-converter plus 2nd-order delta-sigma modulator driving a 3-level PWM output.

---
 rtl/dsm_upconv_param.sv | 170 +++++++++++++++++
 tb/tb_dsm_upconv_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dsm_upconv_param.sv
// ============================================================================
// Module  : dsm_upconv_param
// Brief   : Interpolating up-converter with selectable LO and a 2nd-order
//           delta-sigma modulator driving a 3-level PWM code.
//           Optional macro DSM_LINEAR_INTERP_EN selects linear interpolation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dsm_upconv_param #(
    parameter int W        = 20,
    parameter int OSR_LOG2 = 2,
    parameter int ACC_W    = W + 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1:0]          pwm,
    output logic                ovf,
    output logic                underrun
);

    localparam logic [1:0] c_MODE_BYP = 2'b00;
    localparam logic [1:0] c_MODE_FS4 = 2'b01;
    localparam logic [1:0] c_MODE_FS2 = 2'b10;
    localparam logic [1:0] c_PWM_ZERO = 2'b00;
    localparam logic [1:0] c_PWM_POS  = 2'b01;
    localparam logic [1:0] c_PWM_NEG  = 2'b10;

    localparam int c_XW = ACC_W + 2;

    localparam logic signed [W-1:0]     c_W_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     c_W_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [c_XW-1:0]  c_ACC_MAX  = {3'b000, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_XW-1:0]  c_ACC_MIN  = {3'b111, {(ACC_W-1){1'b0}}};
    localparam logic signed [c_XW-1:0]  c_FB_POS   = c_XW'(1) << (W-1);
    localparam logic signed [c_XW-1:0]  c_FB_NEG   = -c_FB_POS;
    localparam logic signed [ACC_W-1:0] c_Q_POS    = ACC_W'(1) << (W-2);
    localparam logic signed [ACC_W-1:0] c_Q_NEG    = -c_Q_POS;

    logic [OSR_LOG2-1:0] r_phase;
    logic [1:0]          r_lo;
    logic signed [W-1:0] r_cur;
    logic signed [W-1:0] r_interp;
    logic signed [ACC_W-1:0] r_int1;
    logic signed [ACC_W-1:0] r_int2;
    logic [1:0]          r_pwm;
    logic                r_ovf;
    logic                r_underrun;

    logic                    w_boundary;
    logic signed [W-1:0]     w_interp_nxt;
    logic signed [W-1:0]     w_neg;
    logic signed [W-1:0]     w_mix;
    logic signed [c_XW-1:0]  w_fb;
    logic signed [c_XW-1:0]  w_sum1;
    logic signed [c_XW-1:0]  w_sum2;
    logic                    w_clip1;
    logic                    w_clip2;
    logic signed [ACC_W-1:0] w_nxt1;
    logic signed [ACC_W-1:0] w_nxt2;
    logic [1:0]              w_q;

    assign w_boundary = enable && (r_phase == '1);
    assign in_ready   = enable && !reset && (r_phase == '1);
    assign pwm        = enable ? r_pwm : c_PWM_ZERO;
    assign ovf        = r_ovf;
    assign underrun   = r_underrun;

`ifdef DSM_LINEAR_INTERP_EN
    localparam int c_PW = W + OSR_LOG2 + 1;

    logic signed [W-1:0]    r_prev;
    logic signed [c_PW-1:0] w_p;
    logic signed [c_PW-1:0] w_diff;
    logic signed [c_PW-1:0] w_prod;
    logic signed [c_PW-1:0] w_step;

    // Weight runs 1..2^OSR_LOG2 so the boundary slot lands exactly on cur.
    always_comb begin
        w_p          = c_PW'(r_phase) + c_PW'(1);
        w_diff       = c_PW'(r_cur) - c_PW'(r_prev);
        w_prod       = w_diff * w_p;
        w_step       = w_prod >>> OSR_LOG2;
        w_interp_nxt = r_prev + w_step[W-1:0];
    end
`else
    assign w_interp_nxt = r_cur;
`endif

    // LO mixer; negation saturates so -(min) becomes max.
    always_comb begin
        w_neg = (r_interp == c_W_MIN) ? c_W_MAX : -r_interp;
        w_mix = '0;
        case (mode)
            c_MODE_BYP: w_mix = r_interp;
            c_MODE_FS4: begin
                case (r_lo)
                    2'd0:    w_mix = r_interp;
                    2'd2:    w_mix = w_neg;
                    default: w_mix = '0;
                endcase
            end
            c_MODE_FS2: w_mix = r_lo[0] ? w_neg : r_interp;
            default:    w_mix = '0;
        endcase
    end

    always_comb begin
        case (r_pwm)
            c_PWM_POS: w_fb = c_FB_POS;
            c_PWM_NEG: w_fb = c_FB_NEG;
            default:   w_fb = '0;
        endcase
        w_sum1  = c_XW'(r_int1) + c_XW'(w_mix) - w_fb;
        w_sum2  = c_XW'(r_int2) + c_XW'(r_int1) - w_fb;
        w_clip1 = (w_sum1 > c_ACC_MAX) || (w_sum1 < c_ACC_MIN);
        w_clip2 = (w_sum2 > c_ACC_MAX) || (w_sum2 < c_ACC_MIN);
        w_nxt1  = (w_sum1 > c_ACC_MAX) ? c_ACC_MAX[ACC_W-1:0] :
                  (w_sum1 < c_ACC_MIN) ? c_ACC_MIN[ACC_W-1:0] : w_sum1[ACC_W-1:0];
        w_nxt2  = (w_sum2 > c_ACC_MAX) ? c_ACC_MAX[ACC_W-1:0] :
                  (w_sum2 < c_ACC_MIN) ? c_ACC_MIN[ACC_W-1:0] : w_sum2[ACC_W-1:0];
        w_q     = (r_int2 >= c_Q_POS) ? c_PWM_POS :
                  (r_int2 <  c_Q_NEG) ? c_PWM_NEG : c_PWM_ZERO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_phase    <= '1;
            r_lo       <= '0;
            r_cur      <= '0;
            r_interp   <= '0;
            r_int1     <= '0;
            r_int2     <= '0;
            r_pwm      <= c_PWM_ZERO;
            r_ovf      <= 1'b0;
            r_underrun <= 1'b0;
`ifdef DSM_LINEAR_INTERP_EN
            r_prev     <= '0;
`endif
        end else if (enable) begin
            r_phase  <= r_phase + OSR_LOG2'(1);
            r_lo     <= r_lo + 2'd1;
            r_interp <= w_interp_nxt;
            r_int1   <= w_nxt1;
            r_int2   <= w_nxt2;
            r_pwm    <= w_q;
            if (w_clip1 || w_clip2) begin
                r_ovf <= 1'b1;
            end
            if (w_boundary) begin
`ifdef DSM_LINEAR_INTERP_EN
                r_prev <= r_cur;
`endif
                if (in_valid) begin
                    r_cur <= in_data;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dsm_upconv_param.sv
// ============================================================================
// Module  : tb_dsm_upconv_param
// Brief   : Directed self-checking bench for dsm_upconv_param (W=20, OSR 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dsm_upconv_param;

    localparam int W = 20;

    logic                clock    = 1'b0;
    logic                reset    = 1'b1;
    logic                enable   = 1'b1;
    logic [1:0]          mode     = 2'b00;
    logic signed [W-1:0] in_data  = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [1:0]          pwm;
    logic                ovf;
    logic                underrun;

    int checks   = 0;
    int failures = 0;

    // pwm codes after each enabled edge for a constant +2^18 input, mode 00
    logic [1:0] exp_dc  [0:16];
    logic [1:0] exp_fs2 [0:6];
    logic [1:0] exp_fs4 [0:8];

    dsm_upconv_param #(.W(W), .OSR_LOG2(2), .ACC_W(W + 4)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .mode     (mode),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pwm      (pwm),
        .ovf      (ovf),
        .underrun (underrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Reset 3 cycles, release, then one edge so the first sample is in cur.
    task automatic start(input logic [1:0] m, input logic signed [W-1:0] d);
        reset    = 1'b1;
        enable   = 1'b1;
        in_valid = 1'b1;
        mode     = m;
        in_data  = d;
        repeat (3) begin
            tick();
            chk("rst_ready", in_ready, 0);
            chk("rst_pwm", pwm, 0);
        end
        chk("rst_ovf", ovf, 0);
        chk("rst_underrun", underrun, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", in_ready, 1);
        tick();
    endtask

    initial begin
        exp_dc  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                    2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
        exp_fs2 = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        exp_fs4 = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01};

        // Zero input: modulator stays idle.
        start(2'b00, '0);
        for (int n = 0; n < 100; n++) begin
            tick();
            chk("zero_pwm", pwm, 0);
        end
        chk("zero_ovf", ovf, 0);
        chk("zero_underrun", underrun, 0);

        // DC +2^18 with an enable freeze mid-stream; int2 clamps at step 16.
        start(2'b00, 20'sd262144);
        for (int n = 0; n <= 16; n++) begin
            tick();
            chk("dc_pwm", pwm, exp_dc[n]);
            chk("dc_ready", in_ready, (n % 4 == 2) ? 1 : 0);
            if (n == 15) chk("dc_ovf_clear", ovf, 0);
            if (n == 16) chk("dc_ovf_set", ovf, 1);
            if (n == 5) begin
                enable = 1'b0;
                repeat (3) begin
                    tick();
                    chk("frz_pwm", pwm, 0);
                    chk("frz_ready", in_ready, 0);
                end
                enable = 1'b1;
            end
        end
        tick();
        chk("ovf_sticky", ovf, 1);
        reset = 1'b1;
        tick();
        chk("midrst_ovf", ovf, 0);
        chk("midrst_pwm", pwm, 0);
        chk("midrst_ready", in_ready, 0);

        // fs/2 LO with full-scale negative input (saturated negation).
        start(2'b10, -20'sd524288);
        for (int n = 0; n <= 6; n++) begin
            tick();
            chk("fs2_pwm", pwm, exp_fs2[n]);
        end

        // fs/4 LO; step 3 sits exactly on int2 == -T (no -1 output).
        start(2'b01, 20'sd262144);
        for (int n = 0; n <= 8; n++) begin
            tick();
            chk("fs4_pwm", pwm, exp_fs4[n]);
        end

        // Mute.
        start(2'b11, 20'sd262144);
        for (int n = 0; n < 40; n++) begin
            tick();
            chk("mute_pwm", pwm, 0);
        end

        // Two missed boundaries: cur holds +2^18 so output matches the DC run.
        start(2'b00, 20'sd262144);
        in_valid = 1'b0;
        in_data  = '0;
        for (int n = 0; n <= 16; n++) begin
            tick();
            chk("urun_pwm", pwm, exp_dc[n]);
            if (n == 2) chk("urun_before", underrun, 0);
            if (n == 3) chk("urun_set", underrun, 1);
            if (n == 8) begin
                in_valid = 1'b1;
                in_data  = 20'sd262144;
            end
        end
        chk("urun_sticky", underrun, 1);
        reset = 1'b1;
        tick();
        chk("urun_cleared", underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
